kamus_lsu: RTL and testbench

// Parametrised load/store unit between EX and the data-memory port. Takes one B/H/W(/D) access per

---
 rtl/kamus_lsu_if.sv | 42 ++++
 rtl/kamus_lsu.sv | 181 ++++++++++++++++++
 tb/tb_kamus_lsu.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kamus_lsu_if.sv
// Interface bundling the EX-side, data-memory and writeback signals of kamus_lsu.
// The master modport is the LSU itself; slave is the surrounding pipeline/memory.
interface kamus_lsu_if #(
  parameter int XLEN = 32
);
  logic                ex_valid_i;
  logic                ex_ready_o;
  logic                ex_we_i;
  logic [1:0]          ex_width_i;
  logic                ex_unsigned_i;
  logic [XLEN-1:0]     ex_addr_i;
  logic [XLEN-1:0]     ex_wdata_i;
  logic                mem_req_o;
  logic                mem_gnt_i;
  logic [XLEN-1:0]     mem_addr_o;
  logic                mem_we_o;
  logic [XLEN/8-1:0]   mem_be_o;
  logic [XLEN-1:0]     mem_wdata_o;
  logic                mem_rvalid_i;
  logic [XLEN-1:0]     mem_rdata_i;
  logic                mem_err_i;
  logic                wb_valid_o;
  logic [XLEN-1:0]     wb_rdata_o;
  logic                wb_err_o;
  logic [1:0]          wb_cause_o;

  modport master (
    input  ex_valid_i, ex_we_i, ex_width_i, ex_unsigned_i, ex_addr_i, ex_wdata_i,
    output ex_ready_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output wb_valid_o, wb_rdata_o, wb_err_o, wb_cause_o
  );

  modport slave (
    output ex_valid_i, ex_we_i, ex_width_i, ex_unsigned_i, ex_addr_i, ex_wdata_i,
    input  ex_ready_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  wb_valid_o, wb_rdata_o, wb_err_o, wb_cause_o
  );
endinterface

// File: rtl/kamus_lsu.sv
// Load/store unit: one B/H/W(/D) access from EX per transaction onto a req/gnt/rvalid bus,
// with word-crossing split or trap, load extension and error/timeout reporting.
module kamus_lsu #(
  parameter int XLEN           = 32,
  parameter int MISALIGN_SPLIT = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  kamus_lsu_if.master bus
);
  localparam int NB  = XLEN / 8;
  localparam int OW  = $clog2(NB);
  localparam int BW2 = 2 * NB;
  localparam int DW2 = 2 * XLEN;

  typedef enum logic [2:0] {S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_RESP} state_e;

  state_e          state_q;
  logic            we_q, uns_q, split_q;
  logic [1:0]      width_q;
  logic [OW-1:0]   off_q;
  logic [XLEN-1:0] addr2_q, wdata2_q, acc_q;
  logic [NB-1:0]   be2_q;
  logic [31:0]     timer_q;
  logic            req_q, mwe_q, wbv_q, wbe_q;
  logic [XLEN-1:0] addr_q, wdata_q, wbd_q;
  logic [NB-1:0]   be_q;
  logic [1:0]      wbc_q;

  logic [3:0]      size_s;
  logic [OW-1:0]   off_s;
  logic [XLEN-1:0] addr_al_s, shifted_s, mask_s, load_s;
  logic [BW2-1:0]  be_full_s;
  logic [DW2-1:0]  wd_full_s, gather_s;
  logic            cross_s, illegal_s, in_wait_s, tmo_s, sign_s;

  always_comb begin
    size_s    = 4'd1 << bus.ex_width_i;
    off_s     = bus.ex_addr_i[OW-1:0];
    addr_al_s = {bus.ex_addr_i[XLEN-1:OW], {OW{1'b0}}};
    cross_s   = (5'(off_s) + 5'(size_s)) > 5'(NB);
    illegal_s = (bus.ex_width_i == 2'b11) && (XLEN == 32);
    // Both beats' lanes are produced at once: low half is beat 1, high half beat 2.
    be_full_s = ((BW2'(1) << size_s) - BW2'(1)) << off_s;
    wd_full_s = DW2'(bus.ex_wdata_i) << {off_s, 3'b000};

    in_wait_s = (state_q == S_WAIT1) || (state_q == S_WAIT2);
    tmo_s     = in_wait_s && (TIMEOUT_CYCLES != 0) && (timer_q == 32'(TIMEOUT_CYCLES - 1));

    if (state_q == S_WAIT2) begin
      gather_s = {bus.mem_rdata_i, acc_q};
    end else begin
      gather_s = {{XLEN{1'b0}}, bus.mem_rdata_i};
    end
    shifted_s = XLEN'(gather_s >> {off_q, 3'b000});
    mask_s    = (width_q == 2'b11) ? {XLEN{1'b1}} : ((XLEN'(1) << (7'd8 << width_q)) - XLEN'(1));
    case (width_q)
      2'b00:   sign_s = shifted_s[7];
      2'b01:   sign_s = shifted_s[15];
      2'b10:   sign_s = shifted_s[31];
      default: sign_s = shifted_s[XLEN-1];
    endcase
    load_s = (shifted_s & mask_s) | ({XLEN{sign_s & ~uns_q}} & ~mask_s);
  end

  // Transaction FSM with all bus and writeback outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      split_q  <= 1'b0;
      width_q  <= 2'b00;
      off_q    <= {OW{1'b0}};
      addr2_q  <= {XLEN{1'b0}};
      wdata2_q <= {XLEN{1'b0}};
      acc_q    <= {XLEN{1'b0}};
      be2_q    <= {NB{1'b0}};
      timer_q  <= 32'd0;
      req_q    <= 1'b0;
      mwe_q    <= 1'b0;
      addr_q   <= {XLEN{1'b0}};
      wdata_q  <= {XLEN{1'b0}};
      be_q     <= {NB{1'b0}};
      wbv_q    <= 1'b0;
      wbe_q    <= 1'b0;
      wbd_q    <= {XLEN{1'b0}};
      wbc_q    <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ex_valid_i) begin
            we_q     <= bus.ex_we_i;
            uns_q    <= bus.ex_unsigned_i;
            width_q  <= bus.ex_width_i;
            off_q    <= off_s;
            split_q  <= cross_s;
            addr2_q  <= addr_al_s + XLEN'(NB);
            be2_q    <= be_full_s[BW2-1:NB];
            wdata2_q <= wd_full_s[DW2-1:XLEN];
            timer_q  <= 32'd0;
            if (illegal_s) begin
              state_q <= S_RESP;
              wbv_q   <= 1'b1;
              wbe_q   <= 1'b1;
              wbc_q   <= 2'd3;
            end else if (cross_s && (MISALIGN_SPLIT == 0)) begin
              state_q <= S_RESP;
              wbv_q   <= 1'b1;
              wbe_q   <= 1'b1;
              wbc_q   <= 2'd0;
            end else begin
              state_q <= S_REQ1;
              req_q   <= 1'b1;
              addr_q  <= addr_al_s;
              mwe_q   <= bus.ex_we_i;
              be_q    <= be_full_s[NB-1:0];
              wdata_q <= wd_full_s[XLEN-1:0];
            end
          end
        end
        S_REQ1, S_REQ2: begin
          if (bus.mem_gnt_i) begin
            req_q   <= 1'b0;
            timer_q <= 32'd0;
            state_q <= (state_q == S_REQ1) ? S_WAIT1 : S_WAIT2;
          end
        end
        S_WAIT1, S_WAIT2: begin
          if (bus.mem_rvalid_i) begin
            if (bus.mem_err_i) begin
              state_q <= S_RESP;
              wbv_q   <= 1'b1;
              wbe_q   <= 1'b1;
              wbc_q   <= 2'd1;
            end else if ((state_q == S_WAIT1) && split_q) begin
              acc_q   <= bus.mem_rdata_i;
              state_q <= S_REQ2;
              req_q   <= 1'b1;
              addr_q  <= addr2_q;
              mwe_q   <= we_q;
              be_q    <= be2_q;
              wdata_q <= wdata2_q;
            end else begin
              state_q <= S_RESP;
              wbv_q   <= 1'b1;
              wbd_q   <= we_q ? {XLEN{1'b0}} : load_s;
            end
          end else if (tmo_s) begin
            state_q <= S_RESP;
            wbv_q   <= 1'b1;
            wbe_q   <= 1'b1;
            wbc_q   <= 2'd2;
          end else if (TIMEOUT_CYCLES != 0) begin
            timer_q <= timer_q + 32'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          wbv_q   <= 1'b0;
          wbe_q   <= 1'b0;
          wbd_q   <= {XLEN{1'b0}};
          wbc_q   <= 2'd0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ex_ready_o  = (state_q == S_IDLE);
  assign bus.mem_req_o   = req_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_we_o    = mwe_q;
  assign bus.mem_be_o    = be_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.wb_valid_o  = wbv_q;
  assign bus.wb_rdata_o  = wbd_q;
  assign bus.wb_err_o    = wbe_q;
  assign bus.wb_cause_o  = wbc_q;
endmodule

// File: tb/tb_kamus_lsu.sv
// Scoreboard bench for kamus_lsu: expected beats and writebacks are queued as stimulus is
// driven and checked by monitors when the DUT produces them.
module tb_kamus_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int acc_cyc = 0;
  logic prev_wbv = 1'b0;

  typedef struct { logic [31:0] rdata; logic err; logic [1:0] cause; int lat; } wb_exp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } beat_t;
  wb_exp_t wb_q[$];
  beat_t   beat_q[$];

  kamus_lsu_if #(.XLEN(32)) bus_a ();
  kamus_lsu_if #(.XLEN(32)) bus_b ();

  kamus_lsu #(.XLEN(32), .MISALIGN_SPLIT(1), .TIMEOUT_CYCLES(256)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a));
  kamus_lsu #(.XLEN(32), .MISALIGN_SPLIT(0), .TIMEOUT_CYCLES(256)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Writeback monitor: each pulse pops one expectation.
  always @(negedge clk) begin
    if (bus_a.wb_valid_o) begin
      wb_exp_t e;
      check_eq("wb_pulse", 64'(prev_wbv), 64'd0);
      check_eq("wb_expected", 64'(wb_q.size() != 0), 64'd1);
      if (wb_q.size() != 0) begin
        e = wb_q.pop_front();
        check_eq("wb_rdata", 64'(bus_a.wb_rdata_o), 64'(e.rdata));
        check_eq("wb_err", 64'(bus_a.wb_err_o), 64'(e.err));
        check_eq("wb_cause", 64'(bus_a.wb_cause_o), 64'(e.cause));
        // Latency counts edges from accept to the edge that samples wb_valid_o.
        if (e.lat >= 0) check_eq("wb_lat", 64'(cyc + 1 - acc_cyc), 64'(e.lat));
      end
    end
    prev_wbv <= bus_a.wb_valid_o;
  end

  // Bus monitor: each granted beat pops one expectation.
  always @(negedge clk) begin
    if (bus_a.mem_req_o && bus_a.mem_gnt_i) begin
      beat_t b;
      check_eq("beat_expected", 64'(beat_q.size() != 0), 64'd1);
      if (beat_q.size() != 0) begin
        b = beat_q.pop_front();
        check_eq("beat_addr", 64'(bus_a.mem_addr_o), 64'(b.addr));
        check_eq("beat_we", 64'(bus_a.mem_we_o), 64'(b.we));
        check_eq("beat_be", 64'(bus_a.mem_be_o), 64'(b.be));
        if (b.we) check_eq("beat_wdata", 64'(bus_a.mem_wdata_o & lane_mask(b.be)), 64'(b.wdata));
      end
    end
  end

  task automatic push_wb(input logic [31:0] d, input logic e, input logic [1:0] c, input int lat);
    wb_exp_t x;
    x.rdata = d; x.err = e; x.cause = c; x.lat = lat;
    wb_q.push_back(x);
  endtask

  task automatic push_beat(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] d);
    beat_t x;
    x.addr = a; x.we = we; x.be = be; x.wdata = d;
    beat_q.push_back(x);
  endtask

  task automatic issue(input logic we, input logic [1:0] w, input logic uns, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!bus_a.ex_ready_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_eq("ex_ready", 64'(bus_a.ex_ready_o), 64'd1);
    bus_a.ex_valid_i = 1'b1; bus_a.ex_we_i = we; bus_a.ex_width_i = w;
    bus_a.ex_unsigned_i = uns; bus_a.ex_addr_i = a; bus_a.ex_wdata_i = d;
    @(posedge clk); #1;
    acc_cyc = cyc;
    // Scramble operands: the LSU must have captured them at the handshake.
    bus_a.ex_valid_i = 1'b0; bus_a.ex_we_i = ~we; bus_a.ex_width_i = ~w;
    bus_a.ex_unsigned_i = ~uns; bus_a.ex_addr_i = 32'h5A5A_A5A5; bus_a.ex_wdata_i = 32'hCAFE_F00D;
  endtask

  // Serve one beat; rdly < 0 grants without ever responding.
  task automatic serve(input int gdly, input int rdly, input logic [31:0] rd, input logic er);
    int n = 0;
    while (!bus_a.mem_req_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_eq("req_seen", 64'(bus_a.mem_req_o), 64'd1);
    repeat (gdly) begin @(posedge clk); #1; end
    bus_a.mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_a.mem_gnt_i = 1'b0;
    if (rdly >= 0) begin
      repeat (rdly) begin @(posedge clk); #1; end
      bus_a.mem_rvalid_i = 1'b1; bus_a.mem_rdata_i = rd; bus_a.mem_err_i = er;
      @(posedge clk); #1;
      bus_a.mem_rvalid_i = 1'b0; bus_a.mem_err_i = 1'b0; bus_a.mem_rdata_i = 32'h0BAD_0BAD;
    end
  endtask

  task automatic stale_rvalid();
    bus_a.mem_rvalid_i = 1'b1; bus_a.mem_rdata_i = 32'h7777_7777;
    @(posedge clk); #1;
    bus_a.mem_rvalid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((wb_q.size() != 0 || bus_a.wb_valid_o) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check_eq("wb_drained", 64'(wb_q.size()), 64'd0);
  endtask

  initial begin
    bus_a.ex_valid_i = 1'b0; bus_a.ex_we_i = 1'b0; bus_a.ex_width_i = 2'b00; bus_a.ex_unsigned_i = 1'b0;
    bus_a.ex_addr_i = 32'd0; bus_a.ex_wdata_i = 32'd0; bus_a.mem_gnt_i = 1'b0; bus_a.mem_rvalid_i = 1'b0;
    bus_a.mem_rdata_i = 32'd0; bus_a.mem_err_i = 1'b0;
    bus_b.ex_valid_i = 1'b0; bus_b.ex_we_i = 1'b0; bus_b.ex_width_i = 2'b00; bus_b.ex_unsigned_i = 1'b0;
    bus_b.ex_addr_i = 32'd0; bus_b.ex_wdata_i = 32'd0; bus_b.mem_gnt_i = 1'b0; bus_b.mem_rvalid_i = 1'b0;
    bus_b.mem_rdata_i = 32'd0; bus_b.mem_err_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req", 64'(bus_a.mem_req_o), 64'd0);
    check_eq("rst_bus", 64'({bus_a.mem_addr_o, bus_a.mem_be_o, bus_a.mem_we_o}), 64'd0);
    check_eq("rst_wdata", 64'(bus_a.mem_wdata_o), 64'd0);
    check_eq("rst_wb", 64'({bus_a.wb_valid_o, bus_a.wb_err_o, bus_a.wb_cause_o, bus_a.wb_rdata_o}), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_ready", 64'(bus_a.ex_ready_o), 64'd1);

    // SPLIT=0 instance: crossing store traps one cycle after accept with no bus access.
    bus_b.ex_valid_i = 1'b1; bus_b.ex_we_i = 1'b1; bus_b.ex_width_i = 2'b10;
    bus_b.ex_addr_i = 32'h102; bus_b.ex_wdata_i = 32'h1122_3344;
    @(posedge clk); #1;
    bus_b.ex_valid_i = 1'b0;
    @(negedge clk);
    check_eq("b_trap_valid", 64'(bus_b.wb_valid_o), 64'd1);
    check_eq("b_trap_err", 64'({bus_b.wb_err_o, bus_b.wb_cause_o}), 64'({1'b1, 2'd0}));
    check_eq("b_trap_noreq", 64'(bus_b.mem_req_o), 64'd0);
    @(negedge clk);
    check_eq("b_trap_once", 64'({bus_b.wb_valid_o, bus_b.mem_req_o}), 64'd0);

    // Aligned LW, best-case latency.
    push_beat(32'h100, 1'b0, 4'b1111, 32'd0);
    push_wb(32'hDEAD_BEEF, 1'b0, 2'd0, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    serve(0, 0, 32'hDEAD_BEEF, 1'b0);
    wait_done();

    // Byte and half loads, signed and unsigned.
    push_beat(32'h100, 1'b0, 4'b1000, 32'd0);
    push_wb(32'hFFFF_FF80, 1'b0, 2'd0, 3);
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'd0);
    serve(0, 0, 32'h8012_3456, 1'b0);
    wait_done();
    push_beat(32'h100, 1'b0, 4'b1000, 32'd0);
    push_wb(32'h0000_0080, 1'b0, 2'd0, 3);
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'd0);
    serve(0, 0, 32'h8012_3456, 1'b0);
    wait_done();
    push_beat(32'h100, 1'b0, 4'b1100, 32'd0);
    push_wb(32'hFFFF_F00D, 1'b0, 2'd0, -1);
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'd0);
    serve(2, 1, 32'hF00D_1234, 1'b0);
    wait_done();
    push_beat(32'h100, 1'b0, 4'b0011, 32'd0);
    push_wb(32'h0000_8001, 1'b0, 2'd0, -1);
    issue(1'b0, 2'b01, 1'b1, 32'h100, 32'd0);
    serve(1, 0, 32'hFFFF_8001, 1'b0);
    wait_done();

    // Split SW 0x102.
    push_beat(32'h100, 1'b1, 4'b1100, 32'h3344_0000);
    push_beat(32'h104, 1'b1, 4'b0011, 32'h0000_1122);
    push_wb(32'd0, 1'b0, 2'd0, -1);
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h1122_3344);
    serve(0, 0, 32'd0, 1'b0);
    serve(1, 2, 32'd0, 1'b0);
    wait_done();

    // Split LW 0x101: lanes 1..3 of beat 1, lane 0 of beat 2.
    push_beat(32'h100, 1'b0, 4'b1110, 32'd0);
    push_beat(32'h104, 1'b0, 4'b0001, 32'd0);
    push_wb(32'h44AA_BBCC, 1'b0, 2'd0, -1);
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'd0);
    serve(2, 1, 32'hAABB_CCDD, 1'b0);
    serve(0, 0, 32'h1122_3344, 1'b0);
    wait_done();

    // Sub-word stores with shifted lanes.
    push_beat(32'h100, 1'b1, 4'b0010, 32'h0000_A500);
    push_wb(32'd0, 1'b0, 2'd0, 3);
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00A5);
    serve(0, 0, 32'd0, 1'b0);
    wait_done();
    push_beat(32'h104, 1'b1, 4'b1100, 32'hBEEF_0000);
    push_wb(32'd0, 1'b0, 2'd0, -1);
    issue(1'b1, 2'b01, 1'b0, 32'h106, 32'h0000_BEEF);
    serve(0, 1, 32'd0, 1'b0);
    wait_done();

    // Illegal D width at XLEN=32.
    push_wb(32'd0, 1'b1, 2'd3, 1);
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'd0);
    check_eq("illegal_noreq", 64'(bus_a.mem_req_o), 64'd0);
    wait_done();

    // Timeout, then a stale response, then a normal load.
    push_beat(32'h200, 1'b0, 4'b1111, 32'd0);
    push_wb(32'd0, 1'b1, 2'd2, 258);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'd0);
    serve(0, -1, 32'd0, 1'b0);
    wait_done();
    stale_rvalid();
    repeat (2) @(posedge clk);
    #1;
    push_beat(32'h300, 1'b0, 4'b1111, 32'd0);
    push_wb(32'h1234_5678, 1'b0, 2'd0, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'd0);
    serve(0, 0, 32'h1234_5678, 1'b0);
    wait_done();

    // Split LH at 0xFFFFFFFF with bus error on beat 1: no beat 2.
    push_beat(32'hFFFF_FFFC, 1'b0, 4'b1000, 32'd0);
    push_wb(32'd0, 1'b1, 2'd1, 3);
    issue(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'd0);
    serve(0, 0, 32'd0, 1'b1);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      check_eq("err_no_beat2", 64'(bus_a.mem_req_o), 64'd0);
      @(posedge clk); #1;
    end

    // Reset while requesting: request drops asynchronously.
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'd0);
    check_eq("req1_up", 64'(bus_a.mem_req_o), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_req_drop", 64'(bus_a.mem_req_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("rst_ready_req", 64'(bus_a.ex_ready_o), 64'd1);

    // Reset in WAIT1: transaction abandoned, later response ignored.
    push_beat(32'h404, 1'b0, 4'b1111, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h404, 32'd0);
    serve(0, -1, 32'd0, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("rst_wait_req", 64'({bus_a.mem_req_o, bus_a.wb_valid_o}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("rst_ready_wait", 64'(bus_a.ex_ready_o), 64'd1);
    stale_rvalid();
    repeat (2) @(posedge clk);
    #1;
    push_beat(32'h300, 1'b0, 4'b1111, 32'd0);
    push_wb(32'h0BAD_CAFE, 1'b0, 2'd0, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'd0);
    serve(0, 0, 32'h0BAD_CAFE, 1'b0);
    wait_done();

    repeat (3) @(posedge clk);
    check_eq("beats_drained", 64'(beat_q.size()), 64'd0);
    check_eq("wbs_drained", 64'(wb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
